sipo_deser: RTL and testbench

Parametrised serial-to-parallel deserialiser. It shifts a 1-bit stream into a WIDTH-bit word and supports MSB-first or LSB-first bit order. Completed words go to a registered parallel output that uses a valid/ready handshake, and backpressure reaches the serial side. It replaces the plain shift-enable SIPO in receive datapaths where the word consumer can stall and partial words must be discarded on demand.

---
 rtl/sipo_pkg.sv | 16 +
 rtl/sipo_out_reg.sv | 39 +++
 rtl/sipo_deser.sv | 98 +++++++++
 tb/tb_sipo_deser.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// sipo_pkg: shared constants and helpers for the serial-to-parallel deserialiser.
//   cnt_width()      - width of a counter that must hold 0..width inclusive
//   SIPO_MSB_FIRST   - first received bit lands in the word MSB
//   SIPO_LSB_FIRST   - first received bit lands in the word LSB
package sipo_pkg;

   localparam bit SIPO_MSB_FIRST = 1'b1;
   localparam bit SIPO_LSB_FIRST = 1'b0;

   // The counter must represent WIDTH itself (the stalled "word held" state),
   // hence WIDTH+1 distinct values.
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/sipo_out_reg.sv
// sipo_out_reg: WIDTH-bit parallel output register with valid/ready handshake.
// Ports:
//   clk, rst   - clock, async active-high reset
//   load       - capture din this cycle (caller guarantees free=1)
//   din        - word to capture
//   out_ready  - consumer takes p_out this cycle
//   p_out      - registered word
//   out_valid  - p_out holds an unconsumed word
//   free       - register can accept a load this cycle
module sipo_out_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   input  logic             out_ready,
   output logic [WIDTH-1:0] p_out,
   output logic             out_valid,
   output logic             free
);

   // A word being consumed this cycle frees the slot, so a load can land on
   // the same edge without a bubble.
   assign free = ~out_valid | out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_out     <= '0;
         out_valid <= 1'b0;
      end else if (load) begin
         p_out     <= din;
         out_valid <= 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/sipo_deser.sv
// sipo_deser: serial-to-parallel deserialiser with backpressure and flush.
// Ports:
//   clk, rst   - clock, async active-high reset
//   serial_in  - serial data bit, qualified by in_valid
//   in_valid   - serial_in holds a bit
//   in_ready   - a bit can be accepted (low only while a full word is held)
//   flush      - discard the partial or held word (output register untouched)
//   p_out      - registered parallel word
//   out_valid  - p_out holds an unconsumed word
//   out_ready  - consumer takes p_out
//   bit_cnt    - bits currently held in the shift register (0..WIDTH)
module sipo_deser
   import sipo_pkg::*;
#(
   parameter  int WIDTH     = 8,
   parameter  bit MSB_FIRST = SIPO_MSB_FIRST,
   localparam int CW        = cnt_width(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             serial_in,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             flush,
   output logic [WIDTH-1:0] p_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CW-1:0]    bit_cnt
);

   localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   logic [WIDTH-1:0] sr, sr_d, sr_next, load_data;
   logic [CW-1:0]    cnt, cnt_d;
   logic             acc, load, out_free;

   // Only registered state feeds in_ready, so there is no combinational path
   // from out_ready back to the serial source.
   assign in_ready = (cnt != CNT_FULL);
   assign acc      = in_valid & in_ready & ~flush;
   assign bit_cnt  = cnt;

   always_comb begin
      if (MSB_FIRST) sr_next = {sr[WIDTH-2:0], serial_in};
      else           sr_next = {serial_in, sr[WIDTH-1:1]};
   end

   always_comb begin
      sr_d      = sr;
      cnt_d     = cnt;
      load      = 1'b0;
      load_data = sr_next;
      if (flush) begin
         sr_d  = '0;
         cnt_d = '0;
      end else if (acc && cnt == CNT_LAST) begin
         if (out_free) begin
            // Word completes straight into the output register.
            load  = 1'b1;
            cnt_d = '0;
         end else begin
            // Consumer busy: park the full word in sr and stall input.
            sr_d  = sr_next;
            cnt_d = CNT_FULL;
         end
      end else if (cnt == CNT_FULL && out_free) begin
         load      = 1'b1;
         load_data = sr;
         cnt_d     = '0;
      end else if (acc) begin
         sr_d  = sr_next;
         cnt_d = cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr  <= '0;
         cnt <= '0;
      end else begin
         sr  <= sr_d;
         cnt <= cnt_d;
      end
   end

   sipo_out_reg #(.WIDTH(WIDTH)) u_out (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .din       (load_data),
      .out_ready (out_ready),
      .p_out     (p_out),
      .out_valid (out_valid),
      .free      (out_free)
   );

endmodule

// File: tb/tb_sipo_deser.sv
module tb_sipo_deser;

   localparam int W  = 8;
   localparam int CW = 4;

   logic clk = 1'b0;
   logic rst, serial_in, in_valid, flush, out_ready;

   logic          m_in_ready, m_out_valid, l_in_ready, l_out_valid;
   logic [W-1:0]  m_p_out, l_p_out;
   logic [CW-1:0] m_bit_cnt, l_bit_cnt;

   int checks = 0;
   int errors = 0;

   // Expected words per bit order; filled by stimulus, drained by the monitor.
   logic [W-1:0] qm[$];
   logic [W-1:0] ql[$];

   always #5 clk = ~clk;

   sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .rst(rst), .serial_in(serial_in), .in_valid(in_valid),
      .in_ready(m_in_ready), .flush(flush), .p_out(m_p_out),
      .out_valid(m_out_valid), .out_ready(out_ready), .bit_cnt(m_bit_cnt));

   sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .rst(rst), .serial_in(serial_in), .in_valid(in_valid),
      .in_ready(l_in_ready), .flush(flush), .p_out(l_p_out),
      .out_valid(l_out_valid), .out_ready(out_ready), .bit_cnt(l_bit_cnt));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: a handshake completes on the next rising edge whenever
   // out_valid & out_ready are seen here.
   always @(negedge clk) begin
      if (!rst && out_ready) begin
         if (m_out_valid) begin
            if (qm.size() == 0) chk("msb_unexpected_word", m_p_out, 32'hDEAD);
            else                chk("msb_word", m_p_out, qm.pop_front());
         end
         if (l_out_valid) begin
            if (ql.size() == 0) chk("lsb_unexpected_word", l_p_out, 32'hDEAD);
            else                chk("lsb_word", l_p_out, ql.pop_front());
         end
      end
   end

   task automatic send_bit(input logic b);
      serial_in = b;
      in_valid  = 1'b1;
      @(posedge clk); #1;
      in_valid  = 1'b0;
      serial_in = 1'b0;
   endtask

   // Bits go out MSB of 'w' first.
   task automatic send_word(input logic [W-1:0] w);
      for (int i = W - 1; i >= 0; i--) send_bit(w[i]);
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic chk_both_idle(input string name);
      chk({name, "_m_valid"}, {31'd0, m_out_valid}, 32'd0);
      chk({name, "_l_valid"}, {31'd0, l_out_valid}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: timeout reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] vec;
      rst = 1'b1; serial_in = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      #12;
      // Reset state
      chk("rst_p_out",    {24'd0, m_p_out}, 32'd0);
      chk("rst_valid",    {31'd0, m_out_valid}, 32'd0);
      chk("rst_bit_cnt",  {28'd0, m_bit_cnt}, 32'd0);
      chk("rst_in_ready", {31'd0, m_in_ready}, 32'd1);
      @(posedge clk); #1; rst = 1'b0;

      // MSB/LSB word: bits 1,0,1,1,0,0,1,0 -> B2 / 4D
      vec = 8'hB2;
      qm.push_back(8'hB2); ql.push_back(8'h4D);
      for (int i = 0; i < 8; i++) begin
         send_bit(vec[7-i]);
         chk("word1_bit_cnt", {28'd0, m_bit_cnt}, (i == 7) ? 32'd0 : i + 1);
      end
      chk("word1_valid_m", {31'd0, m_out_valid}, 32'd1);
      chk("word1_valid_l", {31'd0, l_out_valid}, 32'd1);
      idle(1);
      chk_both_idle("word1_one_cycle");

      // Backpressure: A5 then 3C with consumer stalled
      out_ready = 1'b0;
      qm.push_back(8'hA5); ql.push_back(8'hA5);
      qm.push_back(8'h3C); ql.push_back(8'h3C);
      send_word(8'hA5);
      chk("bp_first_valid", {31'd0, m_out_valid}, 32'd1);
      send_word(8'h3C);
      chk("bp_bit_cnt",  {28'd0, m_bit_cnt}, 32'd8);
      chk("bp_in_ready", {31'd0, m_in_ready}, 32'd0);
      chk("bp_p_out",    {24'd0, m_p_out}, 32'hA5);
      send_bit(1'b1);  // must be ignored while stalled
      idle(1);
      chk("bp_hold_cnt",   {28'd0, m_bit_cnt}, 32'd8);
      chk("bp_hold_p_out", {24'd0, m_p_out}, 32'hA5);
      out_ready = 1'b1;
      idle(1);
      chk("bp_next_p_out",    {24'd0, m_p_out}, 32'h3C);
      chk("bp_next_valid",    {31'd0, m_out_valid}, 32'd1);
      chk("bp_next_in_ready", {31'd0, m_in_ready}, 32'd1);
      chk("bp_next_cnt",      {28'd0, m_bit_cnt}, 32'd0);
      idle(1);
      chk_both_idle("bp_drained");

      // Flush mid-word: 3 bits then flush with a bit present
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      chk("fl_pre_cnt", {28'd0, m_bit_cnt}, 32'd3);
      flush = 1'b1; serial_in = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      chk("fl_cnt", {28'd0, m_bit_cnt}, 32'd0);
      qm.push_back(8'hFF); ql.push_back(8'hFF);
      send_word(8'hFF);
      chk("fl_ff", {24'd0, m_p_out}, 32'hFF);
      idle(1);

      // Flush while a full word is held: C8 sits in p_out, 01 is parked
      out_ready = 1'b0;
      qm.push_back(8'hC8); ql.push_back(8'h13);
      send_word(8'hC8);
      send_word(8'h01);
      chk("flh_pre_cnt", {28'd0, m_bit_cnt}, 32'd8);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flh_cnt",      {28'd0, m_bit_cnt}, 32'd0);
      chk("flh_in_ready", {31'd0, m_in_ready}, 32'd1);
      chk("flh_p_out_m",  {24'd0, m_p_out}, 32'hC8);
      chk("flh_p_out_l",  {24'd0, l_p_out}, 32'h13);
      chk("flh_valid",    {31'd0, m_out_valid}, 32'd1);
      out_ready = 1'b1;
      idle(2);
      chk_both_idle("flh_drained");

      // Async reset mid-word with a held output word (never consumed)
      out_ready = 1'b0;
      send_word(8'h01);
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      chk("ar_pre_cnt",   {28'd0, m_bit_cnt}, 32'd5);
      chk("ar_pre_valid", {31'd0, m_out_valid}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("ar_p_out",    {24'd0, m_p_out}, 32'd0);
      chk("ar_valid",    {31'd0, m_out_valid}, 32'd0);
      chk("ar_cnt",      {28'd0, m_bit_cnt}, 32'd0);
      chk("ar_in_ready", {31'd0, m_in_ready}, 32'd1);
      chk("ar_p_out_l",  {24'd0, l_p_out}, 32'd0);
      rst = 1'b0; out_ready = 1'b1;
      qm.push_back(8'h1E); ql.push_back(8'h78);
      send_word(8'h1E);
      chk("ar_word_m", {24'd0, m_p_out}, 32'h1E);
      chk("ar_word_l", {24'd0, l_p_out}, 32'h78);
      idle(2);

      chk("sb_msb_empty", qm.size(), 32'd0);
      chk("sb_lsb_empty", ql.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
